tv_checker: RTL and testbench

Synthesizable self-checking test-vector engine: the hardware successor to our simulation-only testbenches. It holds a parametrised vector memory of {stimulus, expected} pairs and drives the stimulus into a combinational DUT one vector at a time. It samples the DUT response after a programmable settle delay and reports the error count, the first failing vector and pass/fail. It sits beside any combinational block under test on the FPGA bring-up board.

---
 rtl/tv_checker.sv | 151 +++++++++++++++
 tb/tb_tv_checker.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tv_checker.sv
// Vector-driven self-checker: drives stored stimulus into a combinational block
// under test, samples its response after SETTLE cycles, and accumulates the results.
module tv_checker #(
    parameter int NIN    = 3,
    parameter int NOUT   = 1,
    parameter int DEPTH  = 8,
    parameter int SETTLE = 1,
    parameter int ERRW   = 8,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [AW:0]          num_vectors,
    input  logic                 load_we,
    input  logic [AW-1:0]        load_addr,
    input  logic [NIN+NOUT-1:0]  load_data,
    output logic [NIN-1:0]       dut_in,
    input  logic [NOUT-1:0]      dut_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERRW-1:0]      err_count,
    output logic                 first_fail_valid,
    output logic [AW-1:0]        first_fail_idx,
    output logic [2:0]           dbg_state
);

    localparam int WCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [AW:0]    DEPTH_N = (AW+1)'(DEPTH);
    localparam logic [WCW-1:0] WLAST   = WCW'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_APPLY = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [AW:0]         n_q, n_d;
    logic [WCW-1:0]      wcnt_q, wcnt_d;
    logic [NIN-1:0]      dut_in_q, dut_in_d;
    logic [ERRW-1:0]     err_q, err_d;
    logic                ffv_q, ffv_d;
    logic [AW-1:0]       ffidx_q, ffidx_d;
    logic [NIN+NOUT-1:0] mem_q [DEPTH];

    logic                idle_or_done;
    logic [AW:0]         n_clamp;
    logic [AW:0]         last_idx;

    assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
    assign n_clamp      = (num_vectors > DEPTH_N) ? DEPTH_N : num_vectors;
    assign last_idx     = n_q - (AW+1)'(1);

    // Vector memory has no reset so a bring-up load survives a run abort.
    always_ff @(posedge clk) begin
        if (load_we && idle_or_done) begin
            mem_q[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            n_q      <= '0;
            wcnt_q   <= '0;
            dut_in_q <= '0;
            err_q    <= '0;
            ffv_q    <= 1'b0;
            ffidx_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            n_q      <= n_d;
            wcnt_q   <= wcnt_d;
            dut_in_q <= dut_in_d;
            err_q    <= err_d;
            ffv_q    <= ffv_d;
            ffidx_q  <= ffidx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        n_d      = n_q;
        wcnt_d   = wcnt_q;
        dut_in_d = dut_in_q;
        err_d    = err_q;
        ffv_d    = ffv_q;
        ffidx_d  = ffidx_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    n_d     = n_clamp;
                    err_d   = '0;
                    ffv_d   = 1'b0;
                    ffidx_d = '0;
                    idx_d   = '0;
                    state_d = (n_clamp == '0) ? S_DONE : S_APPLY;
                end
            end
            S_APPLY: begin
                dut_in_d = mem_q[idx_q][NIN+NOUT-1:NOUT];
                wcnt_d   = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (wcnt_q == WLAST) begin
                    state_d = S_CHECK;
                end else begin
                    wcnt_d = wcnt_q + WCW'(1);
                end
            end
            S_CHECK: begin
                if (dut_out != mem_q[idx_q][NOUT-1:0]) begin
                    if (err_q != '1) begin
                        err_d = err_q + ERRW'(1);
                    end
                    // First-fail capture is independent of counter saturation.
                    if (!ffv_q) begin
                        ffv_d   = 1'b1;
                        ffidx_d = idx_q;
                    end
                end
                if ({1'b0, idx_q} == last_idx) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + AW'(1);
                    state_d = S_APPLY;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign dut_in           = dut_in_q;
    assign busy             = (state_q == S_APPLY) || (state_q == S_WAIT) || (state_q == S_CHECK);
    assign done             = (state_q == S_DONE);
    assign pass             = done && (err_q == '0);
    assign err_count        = err_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_idx   = ffidx_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_tv_checker.sv
// Bench for tv_checker: drives directed runs against a 3-input truth-table block;
// a monitor checks each applied stimulus and each run result against queued expectations.
module tb_tv_checker;

    localparam int NIN    = 3;
    localparam int NOUT   = 1;
    localparam int DEPTH  = 8;
    localparam int SETTLE = 1;
    localparam int ERRW   = 2;
    localparam int AW     = 3;
    localparam int W      = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [AW:0]       num_vectors;
    logic              load_we;
    logic [AW-1:0]     load_addr;
    logic [NIN+NOUT-1:0] load_data;
    logic [NIN-1:0]    dut_in;
    logic [NOUT-1:0]   dut_out;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ERRW-1:0]   err_count;
    logic              first_fail_valid;
    logic [AW-1:0]     first_fail_idx;
    logic [2:0]        dbg_state;

    tv_checker #(
        .NIN(NIN), .NOUT(NOUT), .DEPTH(DEPTH), .SETTLE(SETTLE), .ERRW(ERRW)
    ) u_dut (
        .clk(clk), .reset(reset), .start(start), .num_vectors(num_vectors),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_fail_valid(first_fail_valid),
        .first_fail_idx(first_fail_idx), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Block under test: y = ~b&~c | a&~b with dut_in = {a,b,c}.
    assign dut_out[0] = (~dut_in[1] & ~dut_in[0]) | (dut_in[2] & ~dut_in[1]);

    int errors = 0;
    int checks = 0;
    logic [W-1:0]   exp_q[$];
    logic [NIN-1:0] stim_q[$];
    logic [3:0]     tb_mem[8];
    int  busy_cnt = 0;
    bit  pending  = 1'b0;
    logic [7:0] tt_y = 8'b0011_0001;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // A run is pending once a start is accepted; its result is checked when done shows.
    always @(posedge clk) begin
        if (reset) pending = 1'b0;
        else if (start && !busy) pending = 1'b1;
    end

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (reset) busy_cnt = 0;
        else if (busy) busy_cnt++;
        if (!reset && dbg_state == 3'd3) begin
            if (stim_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL stim_unexpected: got dut_in %0d expected none", dut_in);
            end else begin
                chk("dut_in_seq", dut_in, stim_q.pop_front());
            end
        end
        if (pending && done) begin
            pending = 1'b0;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL result_unexpected: got err %0d expected none", err_count);
            end else begin
                e = exp_q.pop_front();
                chk("err_count", err_count, e[14:13]);
                chk("first_fail_valid", first_fail_valid, e[12]);
                chk("first_fail_idx", first_fail_idx, e[11:9]);
                chk("pass", pass, e[8]);
                chk("busy_cycles", busy_cnt, e[7:0]);
            end
            busy_cnt = 0;
        end
    end

    task automatic load(input int a, input logic [3:0] d);
        @(posedge clk); #1;
        load_we = 1'b1; load_addr = AW'(a); load_data = d;
        @(posedge clk); #1;
        load_we = 1'b0;
        tb_mem[a] = d;
    endtask

    task automatic load_table();
        for (int i = 0; i < 8; i++) begin
            logic [2:0] s;
            s = 3'(i);
            load(i, {s, tt_y[i]});
        end
    endtask

    task automatic expect_run(input int n, input logic [1:0] err, input logic ffv,
                              input logic [2:0] idx, input logic ps, input logic [7:0] lat);
        for (int i = 0; i < n; i++) stim_q.push_back(tb_mem[i][3:1]);
        exp_q.push_back({err, ffv, idx, ps, lat});
    endtask

    task automatic start_run(input int n);
        @(posedge clk); #1;
        start = 1'b1; num_vectors = (AW+1)'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL done_timeout: got done 0 expected 1 within 200 cycles");
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; start = 1'b0; num_vectors = '0;
        load_we = 1'b0; load_addr = '0; load_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_count, 0);
        chk("rst_ffv", first_fail_valid, 0);
        chk("rst_ffidx", first_fail_idx, 0);
        chk("rst_dut_in", dut_in, 0);

        // Full truth table, all expected values correct.
        load_table();
        expect_run(8, 2'd0, 1'b0, 3'd0, 1'b1, 8'd24);
        start_run(8);
        wait_done();
        chk("last_stim_held", dut_in, 7);

        // Zero vectors: immediate done, no busy, stimulus untouched.
        expect_run(0, 2'd0, 1'b0, 3'd0, 1'b1, 8'd0);
        start_run(0);
        wait_done();
        chk("zero_dut_in", dut_in, 7);
        chk("zero_done", done, 1);

        // Expected bits of vectors 3 and 5 inverted.
        load(3, 4'b0111);
        load(5, 4'b1010);
        expect_run(8, 2'd2, 1'b1, 3'd3, 1'b0, 8'd24);
        start_run(8);
        wait_done();
        // Partial run covers only the first injected fault.
        expect_run(5, 2'd1, 1'b1, 3'd3, 1'b0, 8'd15);
        start_run(5);
        wait_done();

        // Reset during vector 4's WAIT aborts the run.
        load_table();
        for (int i = 0; i < 4; i++) stim_q.push_back(tb_mem[i][3:1]);
        start_run(8);
        repeat (13) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_err", err_count, 0);
        chk("abort_dut_in", dut_in, 0);
        chk("abort_ffv", first_fail_valid, 0);
        chk("abort_stim_left", stim_q.size(), 0);
        expect_run(8, 2'd0, 1'b0, 3'd0, 1'b1, 8'd24);
        start_run(8);
        wait_done();

        // All expectations inverted, request clamped to DEPTH, counter saturates.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] s;
            s = 3'(i);
            load(i, {s, ~tt_y[i]});
        end
        expect_run(8, 2'd3, 1'b1, 3'd0, 1'b0, 8'd24);
        start_run(12);
        wait_done();

        // Start and write while busy are ignored.
        load_table();
        expect_run(8, 2'd0, 1'b0, 3'd0, 1'b1, 8'd24);
        start_run(8);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1; num_vectors = 4'd2;
        load_we = 1'b1; load_addr = 3'd0; load_data = 4'b1111;
        @(posedge clk); #1;
        start = 1'b0; load_we = 1'b0;
        wait_done();
        expect_run(8, 2'd0, 1'b0, 3'd0, 1'b1, 8'd24);
        start_run(8);
        wait_done();

        // Write with start in the same cycle is seen by vector 0: stim 111 now expects 1.
        tb_mem[0] = 4'b1111;
        expect_run(8, 2'd1, 1'b1, 3'd0, 1'b0, 8'd24);
        @(posedge clk); #1;
        start = 1'b1; num_vectors = 4'd8;
        load_we = 1'b1; load_addr = 3'd0; load_data = 4'b1111;
        @(posedge clk); #1;
        start = 1'b0; load_we = 1'b0;
        wait_done();

        chk("exp_q_drained", exp_q.size(), 0);
        chk("stim_q_drained", stim_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
